// File: rtl/dm_arb_pkg.sv
// ============================================================================
// dm_arb_pkg : shared FSM encoding and stats counter width for dm_arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } arb_state_t;

   localparam int STAT_W = 16;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin selector, first set req scanning from ptr
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = PTR_W'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// dm_arbiter : round-robin front end for N cores onto one 1-cycle-latency DM.
// Optional per-core grant counters when DM_ARB_STATS_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   input  logic [NUM_CORES-1:0]        core_end,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_we,
   input  logic [DATA_W-1:0]           mem_rdata,
`ifdef DM_ARB_STATS_EN
   input  logic                        stats_clr,
   output logic [NUM_CORES*STAT_W-1:0] grant_cnt,
`endif
   output logic                        all_end,
   output logic                        busy
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CORES - 1);

   arb_state_t        state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              all_end_q;

   logic              pick_valid;
   logic [PTR_W-1:0]  pick_idx;
   logic [PTR_W-1:0]  ptr_next;

   rr_pick #(
      .N     (NUM_CORES),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (core_req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign ptr_next = (win_q == LAST) ? '0 : win_q + PTR_W'(1);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      mem_we     = 1'b0;
      core_ack   = '0;
      core_rdata = rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               win_d   = pick_idx;
               we_d    = core_we[pick_idx];
               addr_d  = core_addr[pick_idx*ADDR_W +: ADDR_W];
               wdata_d = core_wdata[pick_idx*DATA_W +: DATA_W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               mem_we          = 1'b1;
               core_ack[win_q] = 1'b1;
               rr_ptr_d        = ptr_next;
               state_d         = IDLE;
            end else begin
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            core_rdata      = mem_rdata;
            rdata_d         = mem_rdata;
            core_ack[win_q] = 1'b1;
            rr_ptr_d        = ptr_next;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         win_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         all_end_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         win_q     <= win_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         all_end_q <= &core_end;
      end
   end

   // Holding registers only reload on a grant, so the bus keeps its last value when idle.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign all_end   = all_end_q;
   assign busy      = (state_q != IDLE);

`ifdef DM_ARB_STATS_EN
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_stats
      logic [STAT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (stats_clr) begin
            cnt_q <= '0;
         end else if (core_ack[gi] && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_q <= cnt_q + STAT_W'(1);
         end
      end
      assign grant_cnt[gi*STAT_W +: STAT_W] = cnt_q;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// tb_dm_arbiter : directed self-checking bench for dm_arbiter (4 cores, 16b)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

   localparam int NC = 4;
   localparam int DW = 16;
   localparam int AW = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NC-1:0]  core_req, core_we, core_end, core_ack;
   logic [NC*AW-1:0] core_addr;
   logic [NC*DW-1:0] core_wdata;
   logic [DW-1:0]  core_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]  mem_addr;
   logic           mem_we, all_end, busy;
`ifdef DM_ARB_STATS_EN
   logic           stats_clr;
   logic [NC*16-1:0] grant_cnt;
`endif

   int errors = 0;
   int checks = 0;

   dm_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_end   (core_end),
      .core_ack   (core_ack),
      .core_rdata (core_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
`ifdef DM_ARB_STATS_EN
      .stats_clr  (stats_clr),
      .grant_cnt  (grant_cnt),
`endif
      .all_end    (all_end),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Read-only memory contents: one fixed word for the single-read case, a pattern elsewhere.
   function automatic logic [15:0] mem_f(input logic [15:0] a);
      if (a == 16'h0020) return 16'h1234;
      return a ^ 16'hA5A5;
   endfunction

   always @(posedge clk) mem_rdata <= mem_f(mem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
      core_we[c]             = we;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
   endtask

   initial begin
      int order[5];
      order = '{0, 1, 2, 3, 0};
      rst_n      = 1'b0;
      core_req   = '0;
      core_we    = '0;
      core_addr  = '0;
      core_wdata = '0;
      core_end   = '0;
      mem_rdata  = '0;
`ifdef DM_ARB_STATS_EN
      stats_clr  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack",   {28'd0, core_ack}, 32'd0);
      chk("rst_we",    {31'd0, mem_we},   32'd0);
      chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
      chk("rst_busy",  {31'd0, busy},     32'd0);
      chk("rst_rdata", {16'd0, core_rdata}, 32'd0);
      chk("rst_allend", {31'd0, all_end}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single write from core 2
      set_core(2, 1'b1, 16'h0010, 16'hBEEF);
      core_req = 4'b0100;
      step();
      chk("wr_we",    {31'd0, mem_we},    32'd1);
      chk("wr_addr",  {16'd0, mem_addr},  32'h0010);
      chk("wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      chk("wr_ack",   {28'd0, core_ack},  32'b0100);
      chk("wr_busy",  {31'd0, busy},      32'd1);
      core_req = 4'b0000;
      step();
      chk("wr_idle_busy", {31'd0, busy},     32'd0);
      chk("wr_idle_we",   {31'd0, mem_we},   32'd0);
      chk("wr_idle_ack",  {28'd0, core_ack}, 32'd0);
      chk("wr_hold_addr", {16'd0, mem_addr}, 32'h0010);

      // Single read from core 1
      set_core(1, 1'b0, 16'h0020, 16'h0000);
      core_req = 4'b0010;
      step();
      chk("rd_issue_ack", {28'd0, core_ack}, 32'd0);
      chk("rd_issue_we",  {31'd0, mem_we},   32'd0);
      chk("rd_issue_addr", {16'd0, mem_addr}, 32'h0020);
      step();
      chk("rd_ack",   {28'd0, core_ack},   32'b0010);
      chk("rd_rdata", {16'd0, core_rdata}, 32'h1234);
      core_req = 4'b0000;
      step();
      chk("rd_idle_ack",   {28'd0, core_ack},   32'd0);
      chk("rd_hold_rdata", {16'd0, core_rdata}, 32'h1234);

      // Reset during a write access: mem_we must drop without a clock
      set_core(0, 1'b1, 16'h0050, 16'h7777);
      core_req = 4'b0001;
      step();
      chk("rstw_pre_we", {31'd0, mem_we}, 32'd1);
      core_req = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk("rstw_we",   {31'd0, mem_we},   32'd0);
      chk("rstw_ack",  {28'd0, core_ack}, 32'd0);
      chk("rstw_addr", {16'd0, mem_addr}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Reset during RDWAIT of a core 3 read
      set_core(3, 1'b0, 16'h0030, 16'h0000);
      core_req = 4'b1000;
      step();
      step();
      chk("rstr_pre_busy", {31'd0, busy}, 32'd1);
      core_req = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk("rstr_ack",   {28'd0, core_ack},   32'd0);
      chk("rstr_busy",  {31'd0, busy},       32'd0);
      chk("rstr_rdata", {16'd0, core_rdata}, 32'd0);
      chk("rstr_addr",  {16'd0, mem_addr},   32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Contention: four reads from rr_ptr=0; core 0 keeps requesting after its ack
      for (int c = 0; c < NC; c++) set_core(c, 1'b0, 16'h0040 + 16'(c), 16'h0000);
      core_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("cont_issue_busy", {31'd0, busy}, 32'd1);
         step();
         chk("cont_ack",   {28'd0, core_ack},   32'(1 << order[n]));
         chk("cont_rdata", {16'd0, core_rdata}, {16'd0, mem_f(16'h0040 + 16'(order[n]))});
         if (order[n] != 0 || n == 4) core_req[order[n]] = 1'b0;
         step();
      end
      chk("cont_idle_busy", {31'd0, busy}, 32'd0);

`ifdef DM_ARB_STATS_EN
      chk("stat_c0", {16'd0, grant_cnt[0 +: 16]},  32'd2);
      chk("stat_c1", {16'd0, grant_cnt[16 +: 16]}, 32'd1);
      set_core(0, 1'b1, 16'h0060, 16'h1111);
      core_req = 4'b0001;
      step();
      chk("stat_clr_ack", {28'd0, core_ack}, 32'b0001);
      stats_clr = 1'b1;
      core_req  = 4'b0000;
      step();
      stats_clr = 1'b0;
      chk("stat_clr_c0", {16'd0, grant_cnt[0 +: 16]}, 32'd0);
`endif

      // Done aggregation
      core_end = 4'b0001; step();
      chk("end_0001", {31'd0, all_end}, 32'd0);
      core_end = 4'b0011; step();
      chk("end_0011", {31'd0, all_end}, 32'd0);
      core_end = 4'b0111; step();
      chk("end_0111", {31'd0, all_end}, 32'd0);
      core_end = 4'b1111;
      #1;
      chk("end_lag", {31'd0, all_end}, 32'd0);
      step();
      chk("end_1111", {31'd0, all_end}, 32'd1);
      core_end = 4'b1011;
      #1;
      chk("end_fall_lag", {31'd0, all_end}, 32'd1);
      step();
      chk("end_fall", {31'd0, all_end}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
